mem_bus_responder: RTL and testbench

Pin-side memory responder for the 12-bit CPU chip bus: it consumes the chip's `{read_write, write_commit, addr_data}` output word and drives the 12-bit `mem_result` word back into the chip. It sits outside the CPU core, in the FPGA/bench harness, and holds instruction and data memory behind that bus. Reads return combinationally. Stores use a two-phase protocol, address then commit, tracked by a small FSM. An optional preload port fills memory before or between runs.

---
 rtl/common_def.sv | 13 +
 rtl/mem_resp_array.sv | 30 +++
 rtl/mem_bus_responder.sv | 115 +++++++++++
 tb/tb_mem_bus_responder.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/common_def.sv
// Shared definitions for the chip-bus memory responder: bus field positions and the store FSM encoding.
package common_def;
  localparam int unsigned BUS_W          = 12;
  localparam int unsigned BUS_RW_BIT     = 11;
  localparam int unsigned BUS_COMMIT_BIT = 10;
  localparam int unsigned BUS_ADDR_LSB   = 0;
  localparam int unsigned BUS_ADDR_MSB   = 9;

  typedef enum logic {
    IDLE      = 1'b0,
    ADDR_HELD = 1'b1
  } mem_resp_state_t;
endpackage

// File: rtl/mem_resp_array.sv
// Flop-based word array: asynchronous clear, one combinational read port, one synchronous write port.
module mem_resp_array #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_q <= '{default: '0};
    else     mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/mem_bus_responder.sv
// Memory responder for the 12-bit chip bus: combinational reads, two-phase (address/commit) stores.
// Optional preload port enabled by defining MEM_RESP_PRELOAD_EN.
module mem_bus_responder
  import common_def::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 12,
  parameter int unsigned WDATA_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BUS_W-1:0]  bus_in,
`ifdef MEM_RESP_PRELOAD_EN
  input  logic              load_valid,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
`endif
  output logic [DATA_W-1:0] mem_result,
  output logic              write_pending,
  output logic              proto_error,
  output logic [7:0]        write_count
);
  mem_resp_state_t   state_q, state_d;
  logic [ADDR_W-1:0] held_addr_q, held_addr_d;
  logic              proto_error_q, proto_error_d;
  logic [7:0]        write_count_q, write_count_d;

  logic              rw, commit, commit_fire;
  logic [ADDR_W-1:0] bus_addr, rd_addr, arr_waddr;
  logic [DATA_W-1:0] arr_wdata, commit_wdata;
  logic              arr_we;

  assign rw           = bus_in[BUS_RW_BIT];
  assign commit       = bus_in[BUS_COMMIT_BIT];
  assign bus_addr     = ADDR_W'(bus_in[BUS_ADDR_MSB:BUS_ADDR_LSB]);
  assign commit_wdata = DATA_W'(bus_in[WDATA_W-1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      held_addr_q   <= '0;
      proto_error_q <= 1'b0;
      write_count_q <= '0;
    end else begin
      state_q       <= state_d;
      held_addr_q   <= held_addr_d;
      proto_error_q <= proto_error_d;
      write_count_q <= write_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    held_addr_d   = held_addr_q;
    proto_error_d = proto_error_q;
    write_count_d = write_count_q;
    unique case (state_q)
      IDLE: begin
        if (rw && !commit) begin
          held_addr_d = bus_addr;
          state_d     = ADDR_HELD;
        end else if (rw && commit) begin
          proto_error_d = 1'b1;
        end
      end
      ADDR_HELD: begin
        if (rw && !commit) begin
          held_addr_d = bus_addr;
        end else if (rw && commit) begin
          if (write_count_q != 8'hFF) write_count_d = write_count_q + 8'd1;
          state_d = IDLE;
        end else begin
          proto_error_d = 1'b1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Write-phase cycles report the pre-write word at the held address; otherwise the bus address is read.
  always_comb begin
    write_pending = (state_q == ADDR_HELD);
    commit_fire   = (state_q == ADDR_HELD) && rw && commit;
    rd_addr       = (rw && state_q == ADDR_HELD) ? held_addr_q : bus_addr;
    arr_we        = commit_fire;
    arr_waddr     = held_addr_q;
    arr_wdata     = commit_wdata;
`ifdef MEM_RESP_PRELOAD_EN
    load_ready    = !commit_fire;
    if (!commit_fire && load_valid) begin
      arr_we    = 1'b1;
      arr_waddr = load_addr;
      arr_wdata = load_data;
    end
`endif
  end

  mem_resp_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_array (
    .clk  (clk),
    .rst  (rst),
    .we   (arr_we),
    .waddr(arr_waddr),
    .wdata(arr_wdata),
    .raddr(rd_addr),
    .rdata(mem_result)
  );

  assign proto_error = proto_error_q;
  assign write_count = write_count_q;
endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench for mem_bus_responder; preload scenarios run only when MEM_RESP_PRELOAD_EN is defined.
module tb_mem_bus_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] bus_in;
  logic [11:0] mem_result;
  logic        write_pending, proto_error;
  logic [7:0]  write_count;
`ifdef MEM_RESP_PRELOAD_EN
  logic        load_valid;
  logic [9:0]  load_addr;
  logic [11:0] load_data;
  logic        load_ready;
`endif

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  // Transaction-level reference: memory contents plus "a store address is outstanding".
  logic [11:0] m_mem [1024];
  bit          m_pend;
  logic [9:0]  m_addr;
  bit          m_err;
  int          m_cnt;

  mem_bus_responder dut (
    .clk          (clk),
    .rst          (rst),
    .bus_in       (bus_in),
`ifdef MEM_RESP_PRELOAD_EN
    .load_valid   (load_valid),
    .load_addr    (load_addr),
    .load_data    (load_data),
    .load_ready   (load_ready),
`endif
    .mem_result   (mem_result),
    .write_pending(write_pending),
    .proto_error  (proto_error),
    .write_count  (write_count)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    foreach (m_mem[i]) m_mem[i] = '0;
    m_pend = 0;
    m_addr = '0;
    m_err  = 0;
    m_cnt  = 0;
  endtask

  function automatic logic [11:0] model_read(input logic [11:0] w);
    if (w[11] && m_pend) return m_mem[m_addr];
    return m_mem[w[9:0]];
  endfunction

  task automatic model_edge(input logic [11:0] w, input bit lv, input logic [9:0] la,
                            input logic [11:0] ld);
    bit is_commit;
    is_commit = m_pend && w[11] && w[10];
    if (is_commit) begin
      m_mem[m_addr] = {6'b0, w[5:0]};
      if (m_cnt < 255) m_cnt++;
      m_pend = 0;
    end else if (w[11] && !w[10]) begin
      m_pend = 1;
      m_addr = w[9:0];
    end else if (w[11]) begin
      m_err = 1;
    end else if (m_pend) begin
      m_err  = 1;
      m_pend = 0;
    end
    if (lv && !is_commit) m_mem[la] = ld;
  endtask

  // Drive one bus cycle; returns the same-cycle mem_result and the model's prediction for it.
  task automatic step(input logic [11:0] w, input bit lv, input logic [9:0] la, input logic [11:0] ld,
                      output logic [11:0] got, output logic [11:0] exp, output logic got_lr);
    @(negedge clk);
    bus_in = w;
`ifdef MEM_RESP_PRELOAD_EN
    load_valid = lv;
    load_addr  = la;
    load_data  = ld;
`endif
    #1;
    got = mem_result;
    exp = model_read(w);
`ifdef MEM_RESP_PRELOAD_EN
    got_lr = load_ready;
`else
    got_lr = 1'b1;
`endif
    @(posedge clk);
    model_edge(w, lv, la, ld);
    #1;
`ifdef MEM_RESP_PRELOAD_EN
    load_valid = 1'b0;
`endif
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    bus_in = 12'h3A5;
    #1;
    total_cnt++; if (mem_result !== 12'h000) $display("FAIL reset_result: got %h expected 000", mem_result); else pass_cnt++;
    total_cnt++; if (write_pending !== 1'b0) $display("FAIL reset_pending: got %b expected 0", write_pending); else pass_cnt++;
    total_cnt++; if (proto_error !== 1'b0) $display("FAIL reset_err: got %b expected 0", proto_error); else pass_cnt++;
    total_cnt++; if (write_count !== 8'd0) $display("FAIL reset_count: got %0d expected 0", write_count); else pass_cnt++;
`ifdef MEM_RESP_PRELOAD_EN
    total_cnt++; if (load_ready !== 1'b1) $display("FAIL reset_load_ready: got %b expected 1", load_ready); else pass_cnt++;
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_store();
    logic [11:0] got, exp;
    logic lr;
    step(12'h812, 0, '0, '0, got, exp, lr);
    total_cnt++; if (write_pending !== 1'b1) $display("FAIL store_pending_rise: got %b expected 1", write_pending); else pass_cnt++;
    step(12'hC2A, 0, '0, '0, got, exp, lr);
    total_cnt++; if (got !== 12'h000) $display("FAIL store_prewrite: got %h expected 000", got); else pass_cnt++;
    total_cnt++; if (write_pending !== 1'b0) $display("FAIL store_pending_fall: got %b expected 0", write_pending); else pass_cnt++;
    total_cnt++; if (write_count !== 8'd1) $display("FAIL store_count: got %0d expected 1", write_count); else pass_cnt++;
    step(12'h012, 0, '0, '0, got, exp, lr);
    total_cnt++; if (got !== 12'h02A) $display("FAIL store_readback: got %h expected 02a", got); else pass_cnt++;
  endtask

  task automatic test_held_addr();
    logic [11:0] got, exp;
    logic lr;
    repeat (3) step(12'h812, 0, '0, '0, got, exp, lr);
    total_cnt++; if (got !== 12'h02A) $display("FAIL held_result: got %h expected 02a", got); else pass_cnt++;
    step(12'h8F0, 0, '0, '0, got, exp, lr);
    step(12'hC07, 0, '0, '0, got, exp, lr);
    total_cnt++; if (write_count !== 8'd2) $display("FAIL held_count: got %0d expected 2", write_count); else pass_cnt++;
    step(12'h0F0, 0, '0, '0, got, exp, lr);
    total_cnt++; if (got !== 12'h007) $display("FAIL held_new_addr: got %h expected 007", got); else pass_cnt++;
    step(12'h412, 0, '0, '0, got, exp, lr);
    total_cnt++; if (got !== 12'h02A) $display("FAIL held_old_addr: got %h expected 02a", got); else pass_cnt++;
  endtask

  task automatic test_protocol_errors();
    logic [11:0] got, exp;
    logic lr;
    step(12'hC15, 0, '0, '0, got, exp, lr);
    total_cnt++; if (proto_error !== 1'b1) $display("FAIL idle_commit_err: got %b expected 1", proto_error); else pass_cnt++;
    step(12'h015, 0, '0, '0, got, exp, lr);
    total_cnt++; if (got !== 12'h000) $display("FAIL idle_commit_nowrite: got %h expected 000", got); else pass_cnt++;
    total_cnt++; if (proto_error !== 1'b1) $display("FAIL err_sticky: got %b expected 1", proto_error); else pass_cnt++;
    step(12'h803, 0, '0, '0, got, exp, lr);
    step(12'hC11, 0, '0, '0, got, exp, lr);
    step(12'h803, 0, '0, '0, got, exp, lr);
    step(12'h003, 0, '0, '0, got, exp, lr);
    total_cnt++; if (got !== 12'h011) $display("FAIL abandon_read: got %h expected 011", got); else pass_cnt++;
    total_cnt++; if (write_pending !== 1'b0) $display("FAIL abandon_pending: got %b expected 0", write_pending); else pass_cnt++;
    total_cnt++; if (write_count !== 8'd3) $display("FAIL abandon_count: got %0d expected 3", write_count); else pass_cnt++;
  endtask

`ifdef MEM_RESP_PRELOAD_EN
  task automatic test_preload();
    logic [11:0] got, exp;
    logic lr;
    step(12'h000, 1, 10'h005, 12'hABC, got, exp, lr);
    step(12'h005, 0, '0, '0, got, exp, lr);
    total_cnt++; if (got !== 12'hABC) $display("FAIL preload_read: got %h expected abc", got); else pass_cnt++;
    step(12'h820, 0, '0, '0, got, exp, lr);
    step(12'hC3F, 1, 10'h020, 12'hFFF, got, exp, lr);
    total_cnt++; if (lr !== 1'b0) $display("FAIL collide_ready: got %b expected 0", lr); else pass_cnt++;
    step(12'h020, 1, 10'h020, 12'hFFF, got, exp, lr);
    total_cnt++; if (lr !== 1'b1) $display("FAIL retry_ready: got %b expected 1", lr); else pass_cnt++;
    total_cnt++; if (got !== 12'h03F) $display("FAIL collide_commit: got %h expected 03f", got); else pass_cnt++;
    step(12'h020, 0, '0, '0, got, exp, lr);
    total_cnt++; if (got !== 12'hFFF) $display("FAIL collide_final: got %h expected fff", got); else pass_cnt++;
    total_cnt++; if (write_count !== 8'(m_cnt)) $display("FAIL preload_count: got %0d expected %0d", write_count, m_cnt); else pass_cnt++;
  endtask
`endif

  task automatic test_random();
    logic [11:0] got, exp, w, ld;
    logic lr;
    logic [9:0] a, la;
    bit lv;
    int unsigned kind;
    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 9);
      a    = 10'($urandom_range(0, 15)) | (($urandom_range(0, 3) == 0) ? 10'h3F0 : 10'h000);
      if (kind < 4)       w = {2'($urandom_range(0, 1)) & 2'b01, a};
      else if (kind < 7)  w = {2'b10, a};
      else                w = {2'b11, a};
      lv = 0; la = '0; ld = '0;
`ifdef MEM_RESP_PRELOAD_EN
      lv = ($urandom_range(0, 3) == 0);
      la = 10'($urandom_range(0, 15));
      ld = 12'($urandom);
`endif
      step(w, lv, la, ld, got, exp, lr);
      total_cnt++; if (got !== exp) $display("FAIL rand_result[%0d]: got %h expected %h", i, got, exp); else pass_cnt++;
      total_cnt++; if (write_pending !== m_pend) $display("FAIL rand_pending[%0d]: got %b expected %b", i, write_pending, m_pend); else pass_cnt++;
      total_cnt++; if (proto_error !== m_err) $display("FAIL rand_err[%0d]: got %b expected %b", i, proto_error, m_err); else pass_cnt++;
      total_cnt++; if (write_count !== 8'(m_cnt)) $display("FAIL rand_count[%0d]: got %0d expected %0d", i, write_count, m_cnt); else pass_cnt++;
    end
  endtask

  task automatic test_saturate();
    logic [11:0] got, exp;
    logic lr;
    for (int i = 0; i < 260; i++) begin
      step(12'h840, 0, '0, '0, got, exp, lr);
      step(12'hC00 | 12'(i[5:0]), 0, '0, '0, got, exp, lr);
    end
    total_cnt++; if (write_count !== 8'd255) $display("FAIL sat_count: got %0d expected 255", write_count); else pass_cnt++;
    step(12'h040, 0, '0, '0, got, exp, lr);
    total_cnt++; if (got !== exp) $display("FAIL sat_last_data: got %h expected %h", got, exp); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [11:0] got, exp;
    logic lr;
    step(12'h812, 0, '0, '0, got, exp, lr);
    @(negedge clk);
    rst = 1'b1;
    bus_in = 12'h012;
    #1;
    model_reset();
    total_cnt++; if (write_pending !== 1'b0) $display("FAIL midrst_pending: got %b expected 0", write_pending); else pass_cnt++;
    total_cnt++; if (write_count !== 8'd0) $display("FAIL midrst_count: got %0d expected 0", write_count); else pass_cnt++;
    total_cnt++; if (proto_error !== 1'b0) $display("FAIL midrst_err: got %b expected 0", proto_error); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      bus_in = {2'b00, 10'(i * 5)};
      #1;
      total_cnt++; if (mem_result !== 12'h000) $display("FAIL midrst_mem[%0d]: got %h expected 000", i * 5, mem_result); else pass_cnt++;
    end
    @(negedge clk);
    rst = 1'b0;
    step(12'hC15, 0, '0, '0, got, exp, lr);
    total_cnt++; if (proto_error !== 1'b1) $display("FAIL postrst_commit_err: got %b expected 1", proto_error); else pass_cnt++;
    total_cnt++; if (write_count !== 8'd0) $display("FAIL postrst_count: got %0d expected 0", write_count); else pass_cnt++;
    step(12'h012, 0, '0, '0, got, exp, lr);
    total_cnt++; if (got !== 12'h000) $display("FAIL postrst_read: got %h expected 000", got); else pass_cnt++;
  endtask

  initial begin
    rst    = 1'b1;
    bus_in = '0;
`ifdef MEM_RESP_PRELOAD_EN
    load_valid = 1'b0;
    load_addr  = '0;
    load_data  = '0;
`endif
    model_reset();
    test_reset();
    test_store();
    test_held_addr();
    test_protocol_errors();
`ifdef MEM_RESP_PRELOAD_EN
    test_preload();
`endif
    test_random();
    test_saturate();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
